// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its picker.
package dmem_arb_pkg;

    localparam int DATA_W     = 32;
    localparam int RD_LAT_MAX = 7;
    localparam int CNT_W      = 3;

    // Sequencer states: arbitrate, present command, wait out read latency, acknowledge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } arb_state_t;

    // Command captured from the winning master at grant time.
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // Keep the read latency inside what the 3-bit down-counter can express.
    function automatic int clamp_lat(input int lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > RD_LAT_MAX) begin
            return RD_LAT_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way picker: chooses which master gets the data-memory port.
module dmem_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       m0_prio,
    output logic       grant,
    output logic       grant_valid
);

    // A lone requester always wins; a contested round goes to master 0 in
    // priority mode, otherwise to whichever master did not own the last grant.
    always_comb begin
        grant_valid = |req;
        grant       = last_owner;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = m0_prio ? 1'b0 : ~last_owner;
            default: grant = last_owner;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter and access sequencer for the shared data-memory/IO port.
// Address decoding (RAM vs IO on addr[7]) happens downstream; addresses pass through.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int M0_PRIO = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy,
    output logic              owner
);

    localparam int               LAT      = clamp_lat(RD_LAT);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT - 1);
    localparam logic             PRIO_BIT = (M0_PRIO != 0);

    arb_state_t        state_reg;
    cmd_t              cmd_reg;
    cmd_t              win_cmd;
    logic [CNT_W-1:0]  lat_cnt_reg;
    logic              owner_reg;
    logic              mem_we_reg;
    logic              busy_reg;
    logic [1:0]        ack_reg;
    logic [DATA_W-1:0] rdata_reg [2];

    logic [1:0]        req_vec;
    logic              grant;
    logic              grant_valid;
    logic              rd_done;

    assign req_vec = {m1_req, m0_req};

    dmem_rr_pick u_pick (
        .req         (req_vec),
        .last_owner  (owner_reg),
        .m0_prio     (PRIO_BIT),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Route the winning master's command fields toward the command register.
    always_comb begin
        win_cmd = '0;
        if (grant) begin
            win_cmd.we    = m1_we;
            win_cmd.addr  = m1_addr;
            win_cmd.wdata = m1_wdata;
        end else begin
            win_cmd.we    = m0_we;
            win_cmd.addr  = m0_addr;
            win_cmd.wdata = m0_wdata;
        end
    end

    // Last WAIT cycle: the memory data is valid and is captured at this edge.
    assign rd_done = (state_reg == WAIT) && (lat_cnt_reg == '0);

    // Sequencer: grant, present the command, wait out read latency, pulse ack.
    // mem_we and the acks default low so each lasts exactly one cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            cmd_reg     <= '0;
            lat_cnt_reg <= '0;
            owner_reg   <= 1'b1;
            mem_we_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            ack_reg     <= 2'b00;
        end else begin
            mem_we_reg <= 1'b0;
            ack_reg    <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        state_reg  <= ACCESS;
                        owner_reg  <= grant;
                        cmd_reg    <= win_cmd;
                        mem_we_reg <= win_cmd.we;
                        busy_reg   <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cmd_reg.we) begin
                        state_reg          <= ACK;
                        ack_reg[owner_reg] <= 1'b1;
                    end else begin
                        state_reg   <= WAIT;
                        lat_cnt_reg <= LAT_LOAD;
                    end
                end
                WAIT: begin
                    if (lat_cnt_reg == '0) begin
                        state_reg          <= ACK;
                        ack_reg[owner_reg] <= 1'b1;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Per-master read-data holding registers; only the owner's copy is updated.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_rdata
        // Capture memory data for this master at the end of its last WAIT cycle.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                rdata_reg[gi] <= '0;
            end else if (rd_done && (owner_reg == 1'(gi))) begin
                rdata_reg[gi] <= mem_dataout;
            end
        end
    end

    assign mem_addr   = cmd_reg.addr;
    assign mem_datain = cmd_reg.wdata;
    assign mem_we     = mem_we_reg;
    assign busy       = busy_reg;
    assign owner      = owner_reg;
    assign m0_ack     = ack_reg[0];
    assign m1_ack     = ack_reg[1];
    assign m0_rdata   = rdata_reg[0];
    assign m1_rdata   = rdata_reg[1];

endmodule
